// File: rtl/tlp_inject_arbiter_if.sv
// TLP merge bus: passthrough stream, injection channel write ports,
// merged output stream and status. The arbiter is the slave side.
interface tlp_inject_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    logic [DATA_W-1:0]        pt_data;
    logic                     pt_valid;
    logic                     pt_sop;
    logic                     pt_eop;
    logic                     pt_ready;

    logic [NUM_CH*DATA_W-1:0] inj_data;
    logic [NUM_CH-1:0]        inj_valid;
    logic [NUM_CH-1:0]        inj_eop;
    logic [NUM_CH-1:0]        inj_ready;
    logic [NUM_CH-1:0]        inj_enable;

    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_sop;
    logic                     out_eop;
    logic [2:0]               out_src;
    logic                     out_ready;

    logic [NUM_CH-1:0]        inj_ovf;
    logic                     pt_err;
    logic [15:0]              inj_pkt_cnt;

    modport master (
        output pt_data, pt_valid, pt_sop, pt_eop,
        output inj_data, inj_valid, inj_eop, inj_enable,
        output out_ready,
        input  pt_ready, inj_ready,
        input  out_data, out_valid, out_sop, out_eop, out_src,
        input  inj_ovf, pt_err, inj_pkt_cnt
    );

    modport slave (
        input  pt_data, pt_valid, pt_sop, pt_eop,
        input  inj_data, inj_valid, inj_eop, inj_enable,
        input  out_ready,
        output pt_ready, inj_ready,
        output out_data, out_valid, out_sop, out_eop, out_src,
        output inj_ovf, pt_err, inj_pkt_cnt
    );
endinterface

// File: rtl/tlp_inject_arbiter.sv
// Merges one passthrough TLP stream with NUM_CH injection channels onto a
// single TLP stream. Each channel buffers whole packets in its own FIFO;
// arbitration happens only between TLPs (one IDLE bubble per TLP), with
// passthrough priority limited by a starvation guard and round-robin
// between channels.
module tlp_inject_arbiter #(
    parameter int DATA_W       = 32,
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_PT_BURST = 4
) (
    input  logic                pcie_clk,
    input  logic                pcie_reset_n,
    tlp_inject_arbiter_if.slave bus
);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW  = $clog2(MAX_PT_BURST + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_PT, S_INJ} state_t;

    state_t             r_state, w_state_nxt;
    logic [CHW-1:0]     r_gnt, r_rr, w_pick;
    logic [BW-1:0]      r_pt_burst;
    logic               r_first;
    logic               r_pt_err;
    logic [15:0]        r_inj_pkt_cnt;

    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid, r_out_sop, r_out_eop;
    logic [2:0]         r_out_src;

    logic [NUM_CH-1:0]  w_elig, w_empty, w_rd, w_inj_ready, w_inj_ovf;
    logic [DATA_W:0]    w_rd_word [NUM_CH];
    logic [DATA_W:0]    w_inj_word;
    logic               w_any_elig, w_found, w_pt_win, w_adv;
    logic               w_pt_ready, w_pt_take, w_inj_take, w_grant_pt, w_grant_inj;

    // ---------------------------------------------------------------------
    // Per-channel packet FIFO: entries are {eop, data}
    // ---------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W:0] r_mem [FIFO_DEPTH];
        logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
        logic [CW-1:0]   r_count, r_pkt_cnt;
        logic            r_ovf;
        logic            w_full, w_flush, w_wr, w_wr_eop, w_rd_eop;

        assign w_full         = (r_count == CW'(FIFO_DEPTH));
        assign w_wr           = bus.inj_valid[c] & ~w_full;
        assign w_wr_eop       = w_wr & bus.inj_eop[c];
        // Full without a complete packet: the TLP can never fit, so drop it.
        assign w_flush        = w_full & (r_pkt_cnt == '0);
        assign w_rd_eop       = w_rd[c] & r_mem[r_rd_ptr][DATA_W];
        assign w_elig[c]      = bus.inj_enable[c] & (r_pkt_cnt != '0);
        assign w_empty[c]     = (r_count == '0);
        assign w_rd_word[c]   = r_mem[r_rd_ptr];
        assign w_inj_ready[c] = ~w_full;
        assign w_inj_ovf[c]   = r_ovf;

        // Storage write for accepted input words
        always_ff @(posedge pcie_clk) begin
            if (w_wr)
                r_mem[r_wr_ptr] <= {bus.inj_eop[c], bus.inj_data[c*DATA_W +: DATA_W]};
        end

        // Pointers, occupancy, complete-packet count and sticky overflow
        always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
            if (!pcie_reset_n) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_pkt_cnt <= '0;
                r_ovf     <= 1'b0;
            end else begin
                if ((bus.inj_valid[c] & w_full) | w_flush)
                    r_ovf <= 1'b1;
                if (w_flush) begin
                    r_wr_ptr  <= '0;
                    r_rd_ptr  <= '0;
                    r_count   <= '0;
                    r_pkt_cnt <= '0;
                end else begin
                    if (w_wr)
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_rd[c])
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count   <= r_count + CW'(w_wr) - CW'(w_rd[c]);
                    r_pkt_cnt <= r_pkt_cnt + CW'(w_wr_eop) - CW'(w_rd_eop);
                end
            end
        end
    end

    assign w_any_elig = |w_elig;
    assign w_inj_word = w_rd_word[r_gnt];
    assign w_adv      = ~r_out_valid | bus.out_ready;

    // Passthrough keeps priority until it has used its burst allowance while
    // a channel waits; with a zero allowance any waiting channel wins.
    assign w_pt_win = bus.pt_valid & bus.pt_sop &
                      ~(w_any_elig & (r_pt_burst >= BW'(MAX_PT_BURST)));

    // Round-robin channel pick starting at the RR pointer
    always_comb begin
        int k;
        k       = 0;
        w_pick  = r_rr;
        w_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = (int'(r_rr) + i) % NUM_CH;
            if (!w_found && w_elig[k]) begin
                w_found = 1'b1;
                w_pick  = CHW'(k);
            end
        end
    end

    // FSM next state and per-state transfer controls
    always_comb begin
        w_state_nxt = r_state;
        w_pt_ready  = 1'b0;
        w_rd        = '0;
        w_pt_take   = 1'b0;
        w_inj_take  = 1'b0;
        w_grant_pt  = 1'b0;
        w_grant_inj = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only a SOP word may start a TLP; stray words are swallowed.
                w_pt_ready = ~bus.pt_sop;
                if (w_pt_win) begin
                    w_grant_pt  = 1'b1;
                    w_state_nxt = S_PT;
                end else if (w_any_elig) begin
                    w_grant_inj = 1'b1;
                    w_state_nxt = S_INJ;
                end
            end
            S_PT: begin
                w_pt_ready = w_adv;
                if (bus.pt_valid & w_adv) begin
                    w_pt_take = 1'b1;
                    if (bus.pt_eop)
                        w_state_nxt = S_IDLE;
                end
            end
            S_INJ: begin
                if (w_adv & ~w_empty[r_gnt]) begin
                    w_rd[r_gnt] = 1'b1;
                    w_inj_take  = 1'b1;
                    if (w_inj_word[DATA_W])
                        w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, grant bookkeeping, error flag and injected-packet counter
    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_rr          <= '0;
            r_pt_burst    <= '0;
            r_first       <= 1'b0;
            r_pt_err      <= 1'b0;
            r_inj_pkt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_pt) begin
                r_first <= 1'b1;
                if (r_pt_burst < BW'(MAX_PT_BURST))
                    r_pt_burst <= r_pt_burst + 1'b1;
            end else if (w_grant_inj) begin
                r_first    <= 1'b1;
                r_gnt      <= w_pick;
                r_rr       <= CHW'((int'(w_pick) + 1) % NUM_CH);
                r_pt_burst <= '0;
            end else if (w_pt_take | w_inj_take) begin
                r_first <= 1'b0;
            end
            if ((r_state == S_IDLE) & bus.pt_valid & ~bus.pt_sop)
                r_pt_err <= 1'b1;
            if (w_inj_take & w_inj_word[DATA_W])
                r_inj_pkt_cnt <= r_inj_pkt_cnt + 1'b1;
        end
    end

    // Output stage: load on transfer, hold while stalled, drain when taken
    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_src   <= '0;
        end else if (w_pt_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.pt_data;
            r_out_sop   <= r_first;
            r_out_eop   <= bus.pt_eop;
            r_out_src   <= 3'd0;
        end else if (w_inj_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_inj_word[DATA_W-1:0];
            r_out_sop   <= r_first;
            r_out_eop   <= w_inj_word[DATA_W];
            r_out_src   <= 3'(r_gnt) + 3'd1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.pt_ready    = w_pt_ready;
    assign bus.inj_ready   = w_inj_ready;
    assign bus.inj_ovf     = w_inj_ovf;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_sop     = r_out_sop;
    assign bus.out_eop     = r_out_eop;
    assign bus.out_src     = r_out_src;
    assign bus.pt_err      = r_pt_err;
    assign bus.inj_pkt_cnt = r_inj_pkt_cnt;
endmodule

// File: tb/tb_tlp_inject_arbiter.sv
// Directed bench for tlp_inject_arbiter with a packet-level arbitration
// model feeding an expected-word scoreboard.
module tb_tlp_inject_arbiter;
    localparam int DW   = 32;
    localparam int NCH  = 2;
    localparam int FD   = 16;
    localparam int MAXB = 2;

    logic pcie_clk = 1'b0;
    logic pcie_reset_n = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    tlp_inject_arbiter_if #(.DATA_W(DW), .NUM_CH(NCH)) bus();

    tlp_inject_arbiter #(.DATA_W(DW), .NUM_CH(NCH), .FIFO_DEPTH(FD), .MAX_PT_BURST(MAXB)) dut (
        .pcie_clk     (pcie_clk),
        .pcie_reset_n (pcie_reset_n),
        .bus          (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  src;
    } exp_t;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } ptw_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_out_cyc = -1;

    exp_t        exp_q[$];
    ptw_t        drv_q[$];
    bit          pt_go;
    int          src_log[$];

    // packet-level model state
    logic [31:0] m_pt_w[$];
    int          m_pt_len[$];
    logic [31:0] m_ch_w [NCH][$];
    int          m_ch_len [NCH][$];
    int          m_ch_cur [NCH];
    int          m_burst, m_rr, m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge pcie_clk);
        cyc++;
    end

    task automatic drive_pt();
        if (pt_go && drv_q.size() > 0) begin
            bus.pt_valid = 1'b1;
            bus.pt_data  = drv_q[0].d;
            bus.pt_sop   = drv_q[0].sop;
            bus.pt_eop   = drv_q[0].eop;
        end else begin
            bus.pt_valid = 1'b0;
            bus.pt_sop   = 1'b0;
            bus.pt_eop   = 1'b0;
        end
    endtask

    // One clock: sample passthrough handshake mid-cycle, advance after edge.
    task automatic cycle();
        bit acc;
        @(negedge pcie_clk);
        acc = bus.pt_valid && bus.pt_ready;
        @(posedge pcie_clk);
        #1;
        if (acc && drv_q.size() > 0) void'(drv_q.pop_front());
        drive_pt();
    endtask

    task automatic inj_write(input int c, input logic [31:0] d, input logic eop);
        bus.inj_valid[c]           = 1'b1;
        bus.inj_eop[c]             = eop;
        bus.inj_data[c*DW +: DW]   = d;
        cycle();
        bus.inj_valid[c] = 1'b0;
        bus.inj_eop[c]   = 1'b0;
    endtask

    task automatic push_ch_word(input int c, input logic [31:0] d, input logic eop);
        inj_write(c, d, eop);
        m_ch_w[c].push_back(d);
        m_ch_cur[c]++;
        if (eop) begin
            m_ch_len[c].push_back(m_ch_cur[c]);
            m_ch_cur[c] = 0;
        end
    endtask

    task automatic add_ch_pkt(input int c, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) push_ch_word(c, base + 32'(i), i == n - 1);
    endtask

    task automatic add_pt_pkt(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drv_q.push_back('{base + 32'(i), i == 0, i == n - 1});
            m_pt_w.push_back(base + 32'(i));
        end
        m_pt_len.push_back(n);
    endtask

    // Decide packet order from the grant rules, all listed traffic pending.
    task automatic model_run(input logic [NCH-1:0] en);
        bit          elig [NCH];
        bit          any;
        int          pick, n;
        logic [31:0] d;
        while (1) begin
            any = 0;
            for (int c = 0; c < NCH; c++) begin
                elig[c] = en[c] && (m_ch_len[c].size() > 0);
                any     = any | elig[c];
            end
            if (m_pt_len.size() > 0 && !(any && m_burst >= MAXB)) begin
                n = m_pt_len.pop_front();
                for (int i = 0; i < n; i++) begin
                    d = m_pt_w.pop_front();
                    exp_q.push_back('{d, i == 0, i == n - 1, 3'd0});
                end
                if (m_burst < MAXB) m_burst++;
            end else if (any) begin
                pick = -1;
                for (int i = 0; i < NCH; i++)
                    if (pick < 0 && elig[(m_rr + i) % NCH]) pick = (m_rr + i) % NCH;
                n = m_ch_len[pick].pop_front();
                for (int i = 0; i < n; i++) begin
                    d = m_ch_w[pick].pop_front();
                    exp_q.push_back('{d, i == 0, i == n - 1, 3'(pick + 1)});
                end
                m_rr    = (pick + 1) % NCH;
                m_burst = 0;
                m_cnt++;
            end else begin
                break;
            end
        end
    endtask

    // Scoreboard: every accepted output word, plus hold-while-stalled.
    initial begin
        exp_t        e;
        bit          st_pend;
        logic [31:0] st_d;
        logic [2:0]  st_src;
        st_pend = 0;
        st_d    = '0;
        st_src  = '0;
        forever begin
            @(negedge pcie_clk);
            if (!pcie_reset_n) begin
                st_pend = 0;
            end else begin
                if (st_pend) begin
                    chk("stall_valid", 64'(bus.out_valid), 64'd1);
                    chk("stall_data", 64'(bus.out_data), 64'(st_d));
                    chk("stall_src", 64'(bus.out_src), 64'(st_src));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(bus.out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(bus.out_data), 64'(e.d));
                        chk("out_sop", 64'(bus.out_sop), 64'(e.sop));
                        chk("out_eop", 64'(bus.out_eop), 64'(e.eop));
                        chk("out_src", 64'(bus.out_src), 64'(e.src));
                        if (bus.out_sop) src_log.push_back(int'(bus.out_src));
                        if (first_out_cyc < 0) first_out_cyc = cyc;
                    end
                end
                st_pend = bus.out_valid && !bus.out_ready;
                st_d    = bus.out_data;
                st_src  = bus.out_src;
            end
        end
    end

    task automatic do_reset();
        pcie_reset_n   = 1'b0;
        pt_go          = 0;
        drv_q.delete();
        drive_pt();
        bus.pt_data    = '0;
        bus.inj_data   = '0;
        bus.inj_valid  = '0;
        bus.inj_eop    = '0;
        bus.inj_enable = '0;
        bus.out_ready  = 1'b1;
        exp_q.delete();
        m_pt_w.delete();
        m_pt_len.delete();
        for (int c = 0; c < NCH; c++) begin
            m_ch_w[c].delete();
            m_ch_len[c].delete();
            m_ch_cur[c] = 0;
        end
        m_burst = 0;
        m_rr    = 0;
        m_cnt   = 0;
        src_log.delete();
        first_out_cyc = -1;
        repeat (2) @(posedge pcie_clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_flags", 64'({bus.out_sop, bus.out_eop, bus.out_src}), 64'd0);
        chk("rst_pkt_cnt", 64'(bus.inj_pkt_cnt), 64'd0);
        chk("rst_ovf", 64'(bus.inj_ovf), 64'd0);
        chk("rst_pt_err", 64'(bus.pt_err), 64'd0);
        chk("rst_inj_ready", 64'(bus.inj_ready), 64'h3);
        pcie_reset_n = 1'b1;
    endtask

    task automatic chk_src_log(input string nm, input int n, input int s0, input int s1,
                               input int s2, input int s3);
        int ref_s[4];
        ref_s = '{s0, s1, s2, s3};
        chk({nm, "_len"}, 64'(src_log.size()), 64'(n));
        for (int i = 0; i < n && i < src_log.size(); i++)
            chk({nm, "_src"}, 64'(src_log[i]), 64'(ref_s[i]));
    endtask

    initial begin
        int t0;
        bus.pt_data = '0;
        do_reset();

        // 1: single passthrough TLP, then a stray non-SOP word in IDLE
        add_pt_pkt(3, 32'hA000_00A1);
        model_run('0);
        t0    = cyc;
        pt_go = 1;
        drive_pt();
        repeat (10) cycle();
        chk("t1_latency", 64'(first_out_cyc - t0), 64'd2);
        chk("t1_left", 64'(exp_q.size()), 64'd0);
        chk_src_log("t1", 1, 0, 0, 0, 0);
        chk("t1_pt_err0", 64'(bus.pt_err), 64'd0);
        drv_q.push_back('{32'h0000_0055, 1'b0, 1'b0});
        drive_pt();
        repeat (3) cycle();
        chk("t1_stray_taken", 64'(drv_q.size()), 64'd0);
        chk("t1_pt_err1", 64'(bus.pt_err), 64'd1);

        // 2: ch0 two-word packet
        do_reset();
        push_ch_word(0, 32'hDEAD_BEEF, 1'b0);
        push_ch_word(0, 32'h1234_5678, 1'b1);
        model_run(2'b01);
        bus.inj_enable = 2'b01;
        repeat (10) cycle();
        chk("t2_left", 64'(exp_q.size()), 64'd0);
        chk_src_log("t2", 1, 1, 0, 0, 0);
        chk("t2_pkt_cnt", 64'(bus.inj_pkt_cnt), 64'd1);

        // 3: passthrough burst limit with ch1 waiting
        do_reset();
        add_ch_pkt(1, 2, 32'hC100_0000);
        add_pt_pkt(2, 32'hB000_0010);
        add_pt_pkt(3, 32'hB000_0020);
        add_pt_pkt(2, 32'hB000_0030);
        model_run(2'b10);
        bus.inj_enable = 2'b10;
        pt_go = 1;
        drive_pt();
        repeat (25) cycle();
        chk("t3_left", 64'(exp_q.size()), 64'd0);
        chk_src_log("t3", 4, 0, 0, 2, 0);
        chk("t3_pkt_cnt", 64'(bus.inj_pkt_cnt), 64'd1);

        // 4: round-robin between two channels
        do_reset();
        add_ch_pkt(0, 3, 32'hC000_0100);
        add_ch_pkt(0, 1, 32'hC000_0200);
        add_ch_pkt(1, 2, 32'hC100_0100);
        add_ch_pkt(1, 2, 32'hC100_0200);
        model_run(2'b11);
        bus.inj_enable = 2'b11;
        repeat (25) cycle();
        chk("t4_left", 64'(exp_q.size()), 64'd0);
        chk_src_log("t4", 4, 1, 2, 1, 2);
        chk("t4_pkt_cnt", 64'(bus.inj_pkt_cnt), 64'd4);
        chk("t4_pkt_cnt_model", 64'(bus.inj_pkt_cnt), 64'(m_cnt));

        // 5: oversized TLP on ch0 overflows and is flushed
        do_reset();
        bus.inj_enable = 2'b01;
        for (int i = 0; i < FD; i++) inj_write(0, 32'hE000_0000 + 32'(i), 1'b0);
        chk("t5_full_ready", 64'(bus.inj_ready[0]), 64'd0);
        chk("t5_ovf_before", 64'(bus.inj_ovf), 64'd0);
        inj_write(0, 32'hE000_00FF, 1'b0);
        chk("t5_ovf_after", 64'(bus.inj_ovf), 64'h1);
        chk("t5_flushed_ready", 64'(bus.inj_ready[0]), 64'd1);
        repeat (5) cycle();
        push_ch_word(0, 32'hF000_0001, 1'b0);
        push_ch_word(0, 32'hF000_0002, 1'b1);
        model_run(2'b01);
        repeat (10) cycle();
        chk("t5_left", 64'(exp_q.size()), 64'd0);
        chk_src_log("t5", 1, 1, 0, 0, 0);
        chk("t5_pkt_cnt", 64'(bus.inj_pkt_cnt), 64'd1);

        // 6: downstream stall mid-TLP, then reset, then a fresh TLP
        do_reset();
        add_pt_pkt(8, 32'h6000_0000);
        model_run('0);
        pt_go = 1;
        drive_pt();
        repeat (4) cycle();
        bus.out_ready = 1'b0;
        repeat (5) cycle();
        chk("t6_stalled_valid", 64'(bus.out_valid), 64'd1);
        do_reset();
        add_pt_pkt(2, 32'h7000_0000);
        model_run('0);
        pt_go = 1;
        drive_pt();
        repeat (8) cycle();
        chk("t6_left", 64'(exp_q.size()), 64'd0);
        chk_src_log("t6", 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
